// File: rtl/uart_fifo_core.sv
// uart_fifo_core: UART with a shared 16x oversample tick, a TX FSM and a
// 16x-oversampling RX FSM, valid/ready FIFOs in both directions, and sticky
// frame/parity/overrun error flags.

// Synchronous FIFO with first-word-fall-through read port and occupancy count.
module uart_fifo_core_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic [AW:0]  o_count,
  output logic         o_full,
  output logic         o_empty
);
  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  logic [W-1:0]  mem_q [2**AW];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push_ok;
  logic          pop_ok;

  assign o_full  = (count_q == FULL_CNT);
  assign o_empty = (count_q == '0);
  assign push_ok = i_push & ~o_full;
  assign pop_ok  = i_pop & ~o_empty;
  assign o_rdata = mem_q[rd_ptr_q];
  assign o_count = count_q;

  // Storage array; contents are don't-care until written.
  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= i_wdata;
    end
  end

  // Pointers wrap modulo depth; push+pop together keeps the count.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

module uart_fifo_core #(
  parameter int DATA_BITS = 8,
  parameter int CLK_DIV   = 163,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int FIFO_AW   = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx,
  output logic                 o_tx,
  input  logic [DATA_BITS-1:0] i_tx_data,
  input  logic                 i_tx_valid,
  output logic                 o_tx_ready,
  output logic                 o_tx_busy,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  input  logic                 i_rx_ready,
  output logic [FIFO_AW:0]     o_rx_count,
  output logic                 o_err_frame,
  output logic                 o_err_parity,
  output logic                 o_err_overrun,
  input  logic                 i_clr_err
);
  localparam int            CW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_MAX   = CW'(CLK_DIV - 1);
  localparam logic          ODD       = (PARITY == 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP
  } state_t;

  // Parity bit carried on the line for a given payload.
  function automatic logic par_bit(input logic [DATA_BITS-1:0] d);
    return (^d) ^ ODD;
  endfunction

  // ---------------- tick generator ----------------
  logic [CW-1:0] div_q;
  logic          tick;

  assign tick = (div_q == DIV_MAX);

  // Free-running divider; one-cycle tick at CLK_DIV-1.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)    div_q <= '0;
    else if (tick) div_q <= '0;
    else           div_q <= div_q + CW'(1);
  end

  // ---------------- TX path ----------------
  logic [DATA_BITS-1:0] tx_fifo_data;
  logic [FIFO_AW:0]     tx_count;
  logic                 tx_full;
  logic                 tx_empty;
  logic                 tx_pop;
  logic                 tx_bit_end;

  state_t               tx_st_q;
  logic [DATA_BITS-1:0] tx_sh_q;
  logic                 tx_par_q;
  logic                 tx_arm_q;
  logic [3:0]           tx_tcnt_q;
  logic [3:0]           tx_bcnt_q;
  logic                 tx_q;

  uart_fifo_core_fifo #(.W(DATA_BITS), .AW(FIFO_AW)) u_tx_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_tx_valid),
    .i_wdata (i_tx_data),
    .i_pop   (tx_pop),
    .o_rdata (tx_fifo_data),
    .o_count (tx_count),
    .o_full  (tx_full),
    .o_empty (tx_empty)
  );

  assign o_tx_ready = ~tx_full;
  assign o_tx_busy  = (tx_st_q != ST_IDLE) | (tx_count != '0);
  assign o_tx       = tx_q;
  assign tx_bit_end = tick & ~tx_arm_q & (tx_tcnt_q == 4'hF);

  // Pop from IDLE, or straight out of the last stop bit for gapless frames.
  always_comb begin
    tx_pop = 1'b0;
    if (tx_st_q == ST_IDLE) begin
      tx_pop = ~tx_empty;
    end else if ((tx_st_q == ST_STOP) && tx_bit_end && (tx_bcnt_q == STOP_LAST)) begin
      tx_pop = ~tx_empty;
    end else begin
      tx_pop = 1'b0;
    end
  end

  // TX frame sequencer; o_tx is registered and tick-aligned.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      tx_st_q   <= ST_IDLE;
      tx_sh_q   <= '0;
      tx_par_q  <= 1'b0;
      tx_arm_q  <= 1'b0;
      tx_tcnt_q <= 4'd0;
      tx_bcnt_q <= 4'd0;
      tx_q      <= 1'b1;
    end else begin
      if (tick) tx_tcnt_q <= ((tx_st_q == ST_IDLE) || tx_arm_q) ? 4'd0 : tx_tcnt_q + 4'd1;
      case (tx_st_q)
        ST_IDLE: begin
          tx_q <= 1'b1;
          if (tx_pop) begin
            tx_sh_q  <= tx_fifo_data;
            tx_par_q <= par_bit(tx_fifo_data);
            tx_arm_q <= 1'b1;
            tx_st_q  <= ST_START;
          end
        end
        ST_START: begin
          if (tx_arm_q) begin
            // Wait for the next tick so the start bit is exactly 16 ticks.
            if (tick) begin
              tx_arm_q <= 1'b0;
              tx_q     <= 1'b0;
            end
          end else if (tx_bit_end) begin
            tx_q      <= tx_sh_q[0];
            tx_sh_q   <= {1'b0, tx_sh_q[DATA_BITS-1:1]};
            tx_bcnt_q <= 4'd0;
            tx_st_q   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tx_bit_end) begin
            if (tx_bcnt_q == DATA_LAST) begin
              tx_bcnt_q <= 4'd0;
              if (PARITY != 0) begin
                tx_q    <= tx_par_q;
                tx_st_q <= ST_PAR;
              end else begin
                tx_q    <= 1'b1;
                tx_st_q <= ST_STOP;
              end
            end else begin
              tx_q      <= tx_sh_q[0];
              tx_sh_q   <= {1'b0, tx_sh_q[DATA_BITS-1:1]};
              tx_bcnt_q <= tx_bcnt_q + 4'd1;
            end
          end
        end
        ST_PAR: begin
          if (tx_bit_end) begin
            tx_q      <= 1'b1;
            tx_bcnt_q <= 4'd0;
            tx_st_q   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (tx_bit_end) begin
            if (tx_bcnt_q == STOP_LAST) begin
              if (tx_pop) begin
                // Next byte starts on this tick: no idle gap.
                tx_sh_q  <= tx_fifo_data;
                tx_par_q <= par_bit(tx_fifo_data);
                tx_q     <= 1'b0;
                tx_st_q  <= ST_START;
              end else begin
                tx_st_q <= ST_IDLE;
              end
            end else begin
              tx_bcnt_q <= tx_bcnt_q + 4'd1;
            end
          end
        end
        default: begin
          tx_q    <= 1'b1;
          tx_st_q <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------- RX path ----------------
  logic                 sync1_q;
  logic                 sync2_q;
  state_t               rx_st_q;
  logic [3:0]           rx_tcnt_q;
  logic [3:0]           rx_bcnt_q;
  logic [DATA_BITS-1:0] rx_sh_q;
  logic                 rx_pbad_q;
  logic                 rx_push_q;
  logic                 ev_frame_q;
  logic                 ev_par_q;
  logic                 ev_ovr_q;
  logic                 err_frame_q;
  logic                 err_par_q;
  logic                 err_ovr_q;
  logic                 rx_full;
  logic                 rx_empty;

  uart_fifo_core_fifo #(.W(DATA_BITS), .AW(FIFO_AW)) u_rx_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (rx_push_q),
    .i_wdata (rx_sh_q),
    .i_pop   (i_rx_ready),
    .o_rdata (o_rx_data),
    .o_count (o_rx_count),
    .o_full  (rx_full),
    .o_empty (rx_empty)
  );

  assign o_rx_valid    = ~rx_empty;
  assign o_err_frame   = err_frame_q;
  assign o_err_parity  = err_par_q;
  assign o_err_overrun = err_ovr_q;

  // Two-flop synchronizer for the asynchronous serial input (idle high).
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= i_rx;
      sync2_q <= sync1_q;
    end
  end

  // RX frame sequencer; samples mid-bit and issues one-cycle push/error events.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rx_st_q    <= ST_IDLE;
      rx_tcnt_q  <= 4'd0;
      rx_bcnt_q  <= 4'd0;
      rx_sh_q    <= '0;
      rx_pbad_q  <= 1'b0;
      rx_push_q  <= 1'b0;
      ev_frame_q <= 1'b0;
      ev_par_q   <= 1'b0;
      ev_ovr_q   <= 1'b0;
    end else begin
      rx_push_q  <= 1'b0;
      ev_frame_q <= 1'b0;
      ev_par_q   <= 1'b0;
      ev_ovr_q   <= 1'b0;
      case (rx_st_q)
        ST_IDLE: begin
          if (tick && !sync2_q) begin
            rx_tcnt_q <= 4'd0;
            rx_st_q   <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            if (rx_tcnt_q == 4'd7) begin
              rx_tcnt_q <= 4'd0;
              rx_bcnt_q <= 4'd0;
              rx_pbad_q <= 1'b0;
              rx_st_q   <= sync2_q ? ST_IDLE : ST_DATA;
            end else begin
              rx_tcnt_q <= rx_tcnt_q + 4'd1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (rx_tcnt_q == 4'hF) begin
              rx_tcnt_q <= 4'd0;
              rx_sh_q   <= {sync2_q, rx_sh_q[DATA_BITS-1:1]};
              if (rx_bcnt_q == DATA_LAST) begin
                rx_st_q <= (PARITY != 0) ? ST_PAR : ST_STOP;
              end else begin
                rx_bcnt_q <= rx_bcnt_q + 4'd1;
              end
            end else begin
              rx_tcnt_q <= rx_tcnt_q + 4'd1;
            end
          end
        end
        ST_PAR: begin
          if (tick) begin
            if (rx_tcnt_q == 4'hF) begin
              rx_tcnt_q <= 4'd0;
              rx_pbad_q <= (sync2_q != par_bit(rx_sh_q));
              rx_st_q   <= ST_STOP;
            end else begin
              rx_tcnt_q <= rx_tcnt_q + 4'd1;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (rx_tcnt_q == 4'hF) begin
              rx_tcnt_q <= 4'd0;
              rx_st_q   <= ST_IDLE;
              if (!sync2_q) begin
                ev_frame_q <= 1'b1;
              end else if (rx_full) begin
                ev_ovr_q <= 1'b1;
              end else begin
                rx_push_q <= 1'b1;
                ev_par_q  <= rx_pbad_q;
              end
            end else begin
              rx_tcnt_q <= rx_tcnt_q + 4'd1;
            end
          end
        end
        default: begin
          rx_st_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky error flags; a new event wins over a same-cycle clear.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      err_frame_q <= 1'b0;
      err_par_q   <= 1'b0;
      err_ovr_q   <= 1'b0;
    end else begin
      err_frame_q <= ev_frame_q | (err_frame_q & ~i_clr_err);
      err_par_q   <= ev_par_q   | (err_par_q   & ~i_clr_err);
      err_ovr_q   <= ev_ovr_q   | (err_ovr_q   & ~i_clr_err);
    end
  end
endmodule
